// File: rtl/otter_mmio_ctrl.sv
// otter_mmio_ctrl: OTTER IOBUS MMIO peripheral with synchronised, debounced switches/buttons, LED/SSEG
// registers and sticky button events; defining OTTER_MMIO_IRQ_EN adds the MASK register and IRQ output.
module otter_mmio_ctrl #(
  parameter logic [31:0] BASE_ADDR    = 32'h1100_0000,
  parameter int          SW_WIDTH     = 16,
  parameter int          BTN_WIDTH    = 4,
  parameter int          LED_WIDTH    = 16,
  parameter int          SSEG_WIDTH   = 16,
  parameter int          DEBOUNCE_CYC = 500000
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [31:0]           IOBUS_ADDR,
  input  logic [31:0]           IOBUS_OUT,
  input  logic                  IOBUS_WR,
  output logic [31:0]           IOBUS_IN,
  input  logic [SW_WIDTH-1:0]   SWITCHES,
  input  logic [BTN_WIDTH-1:0]  BTNS,
  output logic [LED_WIDTH-1:0]  LEDS,
  output logic [SSEG_WIDTH-1:0] SSEG_DATA,
  output logic                  IRQ
);
  localparam int N = SW_WIDTH + BTN_WIDTH;
  localparam int CW = DEBOUNCE_CYC > 1 ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);
  localparam logic [31:0] A_SW   = BASE_ADDR;
  localparam logic [31:0] A_BTN  = BASE_ADDR + 32'h04;
  localparam logic [31:0] A_EVT  = BASE_ADDR + 32'h08;
  localparam logic [31:0] A_MASK = BASE_ADDR + 32'h0C;
  localparam logic [31:0] A_LED  = BASE_ADDR + 32'h20;
  localparam logic [31:0] A_SSEG = BASE_ADDR + 32'h40;
  // Switches occupy the low bits and buttons the high bits of one shared conditioning pipeline.
  logic [N-1:0] s1_q, s2_q, db_q, db_d, flip;
  logic [N-1:0][CW-1:0] cnt_q, cnt_d;
  logic [LED_WIDTH-1:0] leds_q, leds_d;
  logic [SSEG_WIDTH-1:0] sseg_q, sseg_d;
  logic [BTN_WIDTH-1:0] event_q, event_d, btn_rise, evt_clr;
  logic [31:0] mask_rd;
  logic unused_wdata;
  always_comb begin
    flip = '0;
    cnt_d = cnt_q;
    for (int i = 0; i < N; i++) begin
      flip[i] = (s2_q[i] != db_q[i]) && (cnt_q[i] == CNT_MAX);
      cnt_d[i] = (s2_q[i] == db_q[i] || flip[i]) ? '0 : cnt_q[i] + CW'(1);
    end
    db_d = db_q ^ flip;
    btn_rise = db_d[N-1:SW_WIDTH] & ~db_q[N-1:SW_WIDTH];
    evt_clr = (IOBUS_WR && IOBUS_ADDR == A_EVT) ? IOBUS_OUT[BTN_WIDTH-1:0] : '0;
    event_d = (event_q & ~evt_clr) | btn_rise;
    leds_d = (IOBUS_WR && IOBUS_ADDR == A_LED) ? IOBUS_OUT[LED_WIDTH-1:0] : leds_q;
    sseg_d = (IOBUS_WR && IOBUS_ADDR == A_SSEG) ? IOBUS_OUT[SSEG_WIDTH-1:0] : sseg_q;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_q <= '0;
      s2_q <= '0;
      db_q <= '0;
      cnt_q <= '0;
      leds_q <= '0;
      sseg_q <= '0;
      event_q <= '0;
    end else begin
      s1_q <= {BTNS, SWITCHES};
      s2_q <= s1_q;
      db_q <= db_d;
      cnt_q <= cnt_d;
      leds_q <= leds_d;
      sseg_q <= sseg_d;
      event_q <= event_d;
    end
  end
`ifdef OTTER_MMIO_IRQ_EN
  logic [BTN_WIDTH-1:0] mask_q, mask_d;
  logic irq_q, irq_d;
  always_comb begin
    mask_d = (IOBUS_WR && IOBUS_ADDR == A_MASK) ? IOBUS_OUT[BTN_WIDTH-1:0] : mask_q;
    irq_d = |(event_q & mask_q);
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mask_q <= '0;
      irq_q <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q <= irq_d;
    end
  end
  assign mask_rd = 32'(mask_q);
  assign IRQ = irq_q;
`else
  assign mask_rd = '0;
  assign IRQ = 1'b0;
`endif
  assign IOBUS_IN = IOBUS_ADDR == A_SW   ? 32'(db_q[SW_WIDTH-1:0]) :
                    IOBUS_ADDR == A_BTN  ? 32'(db_q[N-1:SW_WIDTH]) :
                    IOBUS_ADDR == A_EVT  ? 32'(event_q) :
                    IOBUS_ADDR == A_MASK ? mask_rd :
                    IOBUS_ADDR == A_LED  ? 32'(leds_q) :
                    IOBUS_ADDR == A_SSEG ? 32'(sseg_q) : 32'h0;
  assign LEDS = leds_q;
  assign SSEG_DATA = sseg_q;
  assign unused_wdata = ^IOBUS_OUT;
endmodule

// File: tb/tb_otter_mmio_ctrl.sv
// tb_otter_mmio_ctrl: directed bench for otter_mmio_ctrl with a window-based behavioural model checked every cycle.
module tb_otter_mmio_ctrl;
  localparam int D = 4;
  localparam int SW = 16;
  localparam int BTN = 4;
  localparam int N = SW + BTN;
  localparam logic [31:0] BASE = 32'h1100_0000;
`ifdef OTTER_MMIO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n, wr, irq;
  logic [31:0] addr, wdata, rdata;
  logic [SW-1:0] sw;
  logic [BTN-1:0] btn;
  logic [15:0] leds, sseg;
  int checks = 0, failures = 0;
  otter_mmio_ctrl #(.DEBOUNCE_CYC(D)) dut (
    .CLK(clk), .RST_N(rst_n), .IOBUS_ADDR(addr), .IOBUS_OUT(wdata), .IOBUS_WR(wr),
    .IOBUS_IN(rdata), .SWITCHES(sw), .BTNS(btn), .LEDS(leds), .SSEG_DATA(sseg), .IRQ(irq)
  );
  always #5 clk = ~clk;
  // Model: a bit flips once the last D synchronised samples all disagree with it and
  // at least D edges have passed since its previous flip (or reset).
  logic [N-1:0] m_db, m_flip, h[$];
  logic [BTN-1:0] m_event, m_mask, m_rise, m_clr;
  logic [15:0] m_leds, m_sseg;
  logic m_irq, m_irq_n, m_all;
  int age [N];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_db = '0; m_event = '0; m_mask = '0; m_leds = '0; m_sseg = '0; m_irq = 1'b0;
      h.delete();
      repeat (D + 1) h.push_back('0);
      foreach (age[i]) age[i] = 0;
    end else begin
      m_flip = '0;
      for (int b = 0; b < N; b++) begin
        age[b]++;
        m_all = 1'b1;
        for (int m = 1; m <= D; m++) if (h[m][b] == m_db[b]) m_all = 1'b0;
        if (m_all && age[b] >= D) begin m_flip[b] = 1'b1; age[b] = 0; end
      end
      h.push_front({btn, sw});
      void'(h.pop_back());
      m_irq_n = IRQ_EN && |(m_event & m_mask);
      m_rise = m_flip[N-1:SW] & ~m_db[N-1:SW];
      m_clr = (wr && addr == BASE + 32'h08) ? wdata[BTN-1:0] : '0;
      m_event = (m_event & ~m_clr) | m_rise;
      if (IRQ_EN && wr && addr == BASE + 32'h0C) m_mask = wdata[BTN-1:0];
      if (wr && addr == BASE + 32'h20) m_leds = wdata[15:0];
      if (wr && addr == BASE + 32'h40) m_sseg = wdata[15:0];
      m_db = m_db ^ m_flip;
      m_irq = m_irq_n;
    end
  end
  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a == BASE) return 32'(m_db[SW-1:0]);
    if (a == BASE + 32'h04) return 32'(m_db[N-1:SW]);
    if (a == BASE + 32'h08) return 32'(m_event);
    if (a == BASE + 32'h0C) return 32'(m_mask);
    if (a == BASE + 32'h20) return 32'(m_leds);
    if (a == BASE + 32'h40) return 32'(m_sseg);
    return 32'h0;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("model_leds", 32'(leds), 32'(m_leds));
      chk("model_sseg", 32'(sseg), 32'(m_sseg));
      chk("model_irq", 32'(irq), 32'(m_irq));
      chk("model_rdata", rdata, m_read(addr));
    end
  end
  task automatic wr_reg(input logic [31:0] off, input logic [31:0] d);
    @(negedge clk);
    addr = BASE + off; wdata = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask
  task automatic rd(input string name, input logic [31:0] off, input logic [31:0] exp);
    addr = BASE + off;
    #1 chk(name, rdata, exp);
  endtask
  initial begin
    rst_n = 1'b0; wr = 1'b0; addr = BASE + 32'h44; wdata = '0; sw = '0; btn = '0;
    repeat (3) @(negedge clk);
    #1 chk("rst_leds", 32'(leds), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd("rd_sw_reset", 32'h00, 32'h0);
    rd("rd_led_reset", 32'h20, 32'h0);
    rd("rd_sseg_reset", 32'h40, 32'h0);
    rd("rd_unmapped_reset", 32'h44, 32'h0);
    chk("sseg_reset", 32'(sseg), 32'h0);
    wr_reg(32'h20, 32'hFFFF_A5C3);
    #1 chk("leds_write", 32'(leds), 32'h0000_A5C3);
    rd("rd_leds", 32'h20, 32'h0000_A5C3);
    wr_reg(32'h00, 32'h1234_5678);
    rd("rd_sw_ro", 32'h00, 32'h0);
    wr_reg(32'h40, 32'h1234_BEEF);
    #1 chk("sseg_write", 32'(sseg), 32'h0000_BEEF);
    rd("rd_sseg", 32'h40, 32'h0000_BEEF);
    wr_reg(32'h44, 32'hFFFF_FFFF);
    rd("rd_unmapped", 32'h44, 32'h0);
    @(negedge clk);
    addr = BASE; sw = 16'h00F0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      #1 chk("sw_step_latency", rdata, c < 6 ? 32'h0 : 32'h0000_00F0);
    end
    sw[0] = 1'b1;
    repeat (3) @(negedge clk);
    sw[0] = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      #1 chk("sw_glitch_blocked", rdata, 32'h0000_00F0);
    end
    wr_reg(32'h0C, 32'h0000_0004);
    rd("rd_mask", 32'h0C, IRQ_EN ? 32'h4 : 32'h0);
    @(negedge clk);
    addr = BASE + 32'h08; btn = 4'h4;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      #1 chk("btn2_event", rdata, c >= 6 ? 32'h4 : 32'h0);
      chk("btn2_irq", 32'(irq), 32'(IRQ_EN && c >= 7));
    end
    rd("rd_btn_level", 32'h04, 32'h4);
    wr_reg(32'h08, 32'h0000_0004);
    rd("event_w1c", 32'h08, 32'h0);
    @(negedge clk);
    #1 chk("irq_after_clear", 32'(irq), 32'h0);
    repeat (8) @(negedge clk);
    rd("held_no_reevent", 32'h08, 32'h0);
    btn = 4'h0;
    repeat (8) @(negedge clk);
    rd("fall_no_event", 32'h08, 32'h0);
    rd("rd_btn_released", 32'h04, 32'h0);
    @(negedge clk);
    btn = 4'h2;
    repeat (5) @(negedge clk);
    addr = BASE + 32'h08; wdata = 32'h2; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    rd("set_wins_over_clear", 32'h08, 32'h2);
    wr_reg(32'h08, 32'h0);
    rd("w0_keeps_event", 32'h08, 32'h2);
    wr_reg(32'h08, 32'h2);
    rd("event1_cleared", 32'h08, 32'h0);
    wr_reg(32'h0C, 32'hF);
    @(negedge clk);
    btn = 4'hA;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    addr = BASE + 32'h08;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      #1 chk("requalify_event", rdata, c < 6 ? 32'h0 : 32'hA);
    end
    rd("leds_after_reset", 32'h20, 32'h0);
    @(negedge clk);
    #1 chk("irq_mask_reset", 32'(irq), 32'h0);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
